// File: rtl/line_buffer_multi_if.sv
// Pixel stream bundle for line_buffer_multi: input beat plus vertically aligned tap output.
// The master drives pixels in; the slave (line buffer) returns taps. There is no ready signal.
interface line_buffer_multi_if #(
    parameter int DATA_WIDTH = 16,
    parameter int USER_WIDTH = 8,
    parameter int LINES      = 2
);
    logic [DATA_WIDTH-1:0]           in_data;
    logic [USER_WIDTH-1:0]           in_user;
    logic                            in_valid;
    logic [DATA_WIDTH*(LINES+1)-1:0] out_data;
    logic [USER_WIDTH-1:0]           out_user;
    logic                            out_valid;

    modport master (
        output in_data, in_user, in_valid,
        input  out_data, out_user, out_valid
    );

    modport slave (
        input  in_data, in_user, in_valid,
        output out_data, out_user, out_valid
    );
endinterface

// File: rtl/line_buffer_multi.sv
// Multi-line RAM line buffer: current pixel plus the same column of LINES previous lines.
// Latency 2 cycles, 1 beat/clock; no backpressure, in_valid=0 is a bubble.
module line_buffer_multi #(
    parameter int DATA_WIDTH = 16,
    parameter int USER_WIDTH = 8,
    parameter int LINES      = 2,
    parameter int ADDR_WIDTH = 12,
    parameter int IFOUTIMME  = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    line_buffer_multi_if.slave    bus,
    output logic [2:0]            lines_filled,
    output logic                  overflow
);
    localparam int          DEPTH   = 1 << ADDR_WIDTH;
    localparam int          NT      = LINES + 1;
    localparam logic [2:0]  LINES_W = 3'(LINES);

    typedef logic [DATA_WIDTH-1:0] pix_t;

    logic                  started_q, started_d;
    logic [ADDR_WIDTH:0]   col_q, col_d;
    logic [2:0]            lf_q, lf_d;
    logic                  ovf_q, ovf_d;
    logic                  hs;
    logic                  acc;
    logic [ADDR_WIDTH-1:0] rd_addr;

    logic                  vld_s1_q, vld_s1_d;
    pix_t                  data_s1_q, data_s1_d;
    logic [USER_WIDTH-1:0] user_s1_q, user_s1_d;
    logic [ADDR_WIDTH-1:0] col_s1_q, col_s1_d;
    logic [2:0]            lf_s1_q, lf_s1_d;
    logic                  fwd_s1_q, fwd_s1_d;
    pix_t                  fwd_dat_s1_q [LINES];
    pix_t                  fwd_dat_s1_d [LINES];

    pix_t                  ram_rd [LINES];
    pix_t                  tap [NT];

    logic                         out_vld_q, out_vld_d;
    logic [DATA_WIDTH*NT-1:0]     out_dat_q, out_dat_d;
    logic [USER_WIDTH-1:0]        out_user_q, out_user_d;

    // Column bookkeeping; col_q's extra MSB marks "past the last address".
    always_comb begin
        hs        = bus.in_user[0];
        acc       = bus.in_valid && (started_q || hs);
        started_d = started_q | (bus.in_valid & hs);
        col_d     = col_q;
        lf_d      = lf_q;
        ovf_d     = ovf_q;
        rd_addr   = col_q[ADDR_WIDTH-1:0];
        if (acc) begin
            if (hs) begin
                rd_addr = '0;
                col_d   = (ADDR_WIDTH+1)'(1);
            end else begin
                col_d = {1'b0, col_q[ADDR_WIDTH-1:0]} + (ADDR_WIDTH+1)'(1);
                if (col_q[ADDR_WIDTH]) begin
                    ovf_d = 1'b1;
                end
            end
            if (hs && started_q && (lf_q < LINES_W)) begin
                lf_d = lf_q + 3'd1;
            end
        end
    end

    // Stage 1 taps; a same-address write in the previous cycle overrides the read-first data.
    always_comb begin
        tap[0] = data_s1_q;
        for (int k = 1; k < NT; k++) begin
            tap[k] = fwd_s1_q ? fwd_dat_s1_q[k-1] : ram_rd[k-1];
        end
    end

    always_comb begin
        vld_s1_d  = acc;
        data_s1_d = data_s1_q;
        user_s1_d = user_s1_q;
        col_s1_d  = col_s1_q;
        lf_s1_d   = lf_s1_q;
        fwd_s1_d  = fwd_s1_q;
        for (int k = 0; k < LINES; k++) begin
            fwd_dat_s1_d[k] = fwd_dat_s1_q[k];
        end
        if (acc) begin
            data_s1_d = bus.in_data;
            user_s1_d = bus.in_user;
            col_s1_d  = rd_addr;
            lf_s1_d   = lf_d;
            fwd_s1_d  = vld_s1_q && (col_s1_q == rd_addr);
            for (int k = 0; k < LINES; k++) begin
                fwd_dat_s1_d[k] = tap[k];
            end
        end
    end

    for (genvar g = 0; g < LINES; g++) begin : g_ram
        pix_t mem [DEPTH];
        pix_t rd_q;

        // RAM g holds line g+1 above; it is fed by the tap one line younger.
        always_ff @(posedge clk) begin
            if (vld_s1_q) begin
                mem[col_s1_q] <= tap[g];
            end
            if (acc) begin
                rd_q <= mem[rd_addr];
            end
        end

        assign ram_rd[g] = rd_q;
    end

    always_comb begin
        out_vld_d  = vld_s1_q && ((IFOUTIMME != 0) || (lf_s1_q == LINES_W));
        out_dat_d  = out_dat_q;
        out_user_d = out_user_q;
        if (out_vld_d) begin
            out_user_d = user_s1_q;
            for (int k = 0; k < NT; k++) begin
                if ((IFOUTIMME != 0) && (int'(lf_s1_q) < k)) begin
                    out_dat_d[k*DATA_WIDTH +: DATA_WIDTH] = '0;
                end else begin
                    out_dat_d[k*DATA_WIDTH +: DATA_WIDTH] = tap[k];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            started_q  <= 1'b0;
            col_q      <= '0;
            lf_q       <= '0;
            ovf_q      <= 1'b0;
            vld_s1_q   <= 1'b0;
            data_s1_q  <= '0;
            user_s1_q  <= '0;
            col_s1_q   <= '0;
            lf_s1_q    <= '0;
            fwd_s1_q   <= 1'b0;
            for (int k = 0; k < LINES; k++) begin
                fwd_dat_s1_q[k] <= '0;
            end
            out_vld_q  <= 1'b0;
            out_dat_q  <= '0;
            out_user_q <= '0;
        end else begin
            started_q  <= started_d;
            col_q      <= col_d;
            lf_q       <= lf_d;
            ovf_q      <= ovf_d;
            vld_s1_q   <= vld_s1_d;
            data_s1_q  <= data_s1_d;
            user_s1_q  <= user_s1_d;
            col_s1_q   <= col_s1_d;
            lf_s1_q    <= lf_s1_d;
            fwd_s1_q   <= fwd_s1_d;
            for (int k = 0; k < LINES; k++) begin
                fwd_dat_s1_q[k] <= fwd_dat_s1_d[k];
            end
            out_vld_q  <= out_vld_d;
            out_dat_q  <= out_dat_d;
            out_user_q <= out_user_d;
        end
    end

    assign bus.out_valid = out_vld_q;
    assign bus.out_data  = out_dat_q;
    assign bus.out_user  = out_user_q;
    assign lines_filled  = lf_q;
    assign overflow      = ovf_q;
endmodule
